// File: rtl/mcu_bus_pkg.sv
// Shared definitions for the MCU memory-port arbiter slice.
//   - arb_state_e : arbiter FSM encoding (IDLE / ACCESS / RESP)
//   - DEF_ADDR_W / DEF_DATA_W : default bus widths
//   - MASTER_* : fixed master slot indices (slot 0 is the CPU)
//   - idx_w() / eff_latency() : parameter helpers
package mcu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } arb_state_e;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;

  localparam int MASTER_CPU    = 0;
  localparam int MASTER_LOADER = 1;

  // Width of a master index; a single master still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero latency memory is meaningless; it behaves as a one-cycle memory.
  function automatic int eff_latency(input int lat);
    return (lat < 1) ? 1 : lat;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
//   req        : per-master request levels
//   last_grant : index of the master served most recently
//   winner_oh  : one-hot winner (all zero when nothing requests)
//   winner_idx : index of the winner
//   any_req    : at least one request present
// Search order is last_grant+1, last_grant+2, ... wrapping modulo NUM_REQ.
module rr_priority_picker
  import mcu_bus_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] sel;

  // Walk from the farthest candidate to the nearest; the last hit wins,
  // which is the first requester after last_grant in rotation order.
  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    sel        = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      sel = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (req[sel]) begin
        winner_oh            = '0;
        winner_oh[sel]       = 1'b1;
        winner_idx           = sel;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single MCU memory port among NUM_REQ bus masters.
// One transaction at a time, round-robin, fixed memory latency.
//   clk, rst (async, active low)
//   req/we/addr/wdata : per-master request, packed master i at slice i
//   gnt   : one-hot grant, capture through ack cycle
//   ack   : one-cycle completion pulse; err/rdata valid with it
//   mem_* : memory/peripheral decoder side
// Sequence per transaction: IDLE (capture) -> ACCESS x MEM_LATENCY -> RESP.
module mem_port_arbiter
  import mcu_bus_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_write,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_error
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int LAT   = eff_latency(MEM_LATENCY);
  localparam int CNT_W = 3;

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;

  assign addr_a  = addr;
  assign wdata_a = wdata;

  arb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] last_grant;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .any_req    (pick_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      win_idx    <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);  // master 0 wins first
      gnt        <= '0;
      ack        <= '0;
      err        <= '0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_write  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          mem_write <= 1'b0;
          if (pick_any) begin
            win_idx   <= pick_idx;
            gnt       <= pick_oh;
            mem_addr  <= addr_a[pick_idx];
            mem_wdata <= wdata_a[pick_idx];
            mem_write <= we[pick_idx];
            cnt       <= CNT_W'(LAT);
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            // Last held cycle: memory response is valid now. The write
            // strobe drops on this edge so it spans exactly LAT cycles.
            if (!mem_write) rdata <= mem_rdata;
            ack       <= gnt;
            err       <= gnt & {NUM_REQ{mem_error}};
            mem_write <= 1'b0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          last_grant <= win_idx;
          gnt        <= '0;
          ack        <= '0;
          err        <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam logic [31:0] K = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req, we, gnt, ack, err;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_write, mem_error;

  // memory model: either fixed response or a function of the address
  logic          use_fixed;
  logic [DW-1:0] fix_rdata;
  logic          fix_err;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = use_fixed ? fix_rdata : (mem_addr ^ K);
    mem_error = use_fixed ? fix_err : (mem_addr[1:0] == 2'b11);
  end

  mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_error(mem_error)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
  endtask

  task automatic do_reset();
    req = '0; we = '0; addr = '0; wdata = '0;
    rst = 1'b0;
    #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]  req, we;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] w0, w1, mrd;
    logic          merr;
    int            win;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic run_vec(input vec_t v, input int idx);
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    ea = (v.win == 1) ? v.a1 : v.a0;
    ew = (v.win == 1) ? v.w1 : v.w0;
    @(posedge clk); #1;
    req = v.req; we = v.we; addr = {v.a1, v.a0}; wdata = {v.w1, v.w0};
    fix_rdata = v.mrd; fix_err = v.merr;
    @(negedge clk);
    chk($sformatf("v%0d_pre_gnt", idx), gnt, 0);
    for (int t = 0; t <= LAT; t++) begin
      @(negedge clk);
      chk($sformatf("v%0d_gnt_t%0d", idx, t), gnt, oh(v.win));
      chk($sformatf("v%0d_ack_t%0d", idx, t), ack, (t == LAT) ? oh(v.win) : '0);
      chk($sformatf("v%0d_mem_write_t%0d", idx, t), mem_write, (t < LAT) ? v.we[v.win] : 1'b0);
      if (t == 0) begin
        chk($sformatf("v%0d_mem_addr", idx), mem_addr, ea);
        chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, ew);
      end
      if (t == LAT) begin
        chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rd);
        chk($sformatf("v%0d_err", idx), err, v.exp_err ? oh(v.win) : '0);
      end else begin
        chk($sformatf("v%0d_err_t%0d", idx, t), err, 0);
      end
    end
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    chk($sformatf("v%0d_idle_gnt", idx), gnt, 0);
    chk($sformatf("v%0d_idle_ack", idx), ack, 0);
  endtask

  // random-phase model state
  logic [N-1:0]  pend;
  logic [N-1:0]  r_edge, w_edge;
  logic [AW-1:0] a_edge [N];
  logic [DW-1:0] d_edge [N];
  int            mt, cur, mlast, p;
  logic          cur_we;
  logic [AW-1:0] cur_a;
  logic [DW-1:0] cur_w, m_rdata;
  int            k, seen, last_c;

  initial begin
    use_fixed = 1'b1; fix_rdata = '0; fix_err = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    #2 rst = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b1;

    //           req    we     a0        a1        w0            w1            mrd           merr win exp_rd        exp_err
    tbl[0] = '{2'b01, 2'b00, 32'h10,  32'h0,   32'h0,        32'h0,        32'hE3A0_0001, 1'b0, 0, 32'hE3A0_0001, 1'b0};
    tbl[1] = '{2'b10, 2'b10, 32'h0,   32'h100, 32'h0,        32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1, 32'hE3A0_0001, 1'b0};
    tbl[2] = '{2'b10, 2'b00, 32'h0,   32'h204, 32'h0,        32'h0,        32'h1234_5678, 1'b1, 1, 32'h1234_5678, 1'b1};
    tbl[3] = '{2'b11, 2'b00, 32'h300, 32'h400, 32'h0,        32'h0,        32'hCAFE_F00D, 1'b0, 0, 32'hCAFE_F00D, 1'b0};
    tbl[4] = '{2'b11, 2'b11, 32'h500, 32'h600, 32'h1111_1111, 32'h2222_2222, 32'h0,        1'b0, 1, 32'hCAFE_F00D, 1'b0};
    tbl[5] = '{2'b01, 2'b01, 32'h8,   32'h0,   32'h5,        32'h0,        32'h0,        1'b1, 0, 32'hCAFE_F00D, 1'b1};
    tbl[6] = '{2'b11, 2'b00, 32'h700, 32'h704, 32'h0,        32'h0,        32'h0000_0077, 1'b0, 1, 32'h0000_0077, 1'b0};
    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // contention after reset, then continuous requests: 0,1,0,1,0,1
    do_reset();
    use_fixed = 1'b0;
    @(posedge clk); #1;
    req = 2'b11; we = 2'b00; addr = {32'h2001, 32'h1000};
    k = 0; seen = 0; last_c = 0;
    while (seen < 6 && k < 40) begin
      @(negedge clk); k++;
      if (ack != 0) begin
        chk($sformatf("rr_order%0d", seen), ack, (seen % 2 == 0) ? 2'b01 : 2'b10);
        chk($sformatf("rr_rdata%0d", seen), rdata, (seen % 2 == 0) ? (32'h1000 ^ K) : (32'h2001 ^ K));
        chk($sformatf("rr_spacing%0d", seen), k - last_c, LAT + 2);
        last_c = k; seen++;
      end
    end
    chk("rr_count", seen, 6);
    @(posedge clk); #1 req = '0;

    // reset during the first ACCESS cycle of a write
    use_fixed = 1'b1; fix_err = 1'b0; fix_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    req = 2'b10; we = 2'b10; addr = {32'h100, 32'h0}; wdata = {32'hDEAD_BEEF, 32'h0};
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_gnt_before", gnt, 2'b10);
    chk("rst_mid_write_before", mem_write, 1'b1);
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge clk);
    chk("rst_mid_hold_ack", ack, 0);
    chk("rst_mid_hold_gnt", gnt, 0);
    @(posedge clk); #1;
    rst = 1'b1; req = 2'b11; we = 2'b00; addr = {32'h44, 32'h40};
    k = 0;
    do begin @(negedge clk); k++; end while (gnt == 0 && k < 6);
    chk("post_rst_first_gnt", gnt, 2'b01);
    k = 0;
    do begin @(negedge clk); k++; end while (ack == 0 && k < 6);
    chk("post_rst_first_ack", ack, 2'b01);
    @(posedge clk); #1 req = '0;

    // randomized traffic against a transaction-level model
    do_reset();
    use_fixed = 1'b0;
    pend = '0; mt = -1; cur = 0; mlast = N - 1; m_rdata = '0;
    cur_we = 1'b0; cur_a = '0; cur_w = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      r_edge = req; w_edge = we;
      for (int m = 0; m < N; m++) begin
        a_edge[m] = addr[m*AW +: AW];
        d_edge[m] = wdata[m*DW +: DW];
      end
      for (int m = 0; m < N; m++) begin
        if (!pend[m]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[m] = 1'b1; req[m] = 1'b1; we[m] = 1'($urandom_range(0, 1));
            addr[m*AW +: AW] = $urandom; wdata[m*DW +: DW] = $urandom;
          end else begin
            req[m] = 1'b0;
          end
        end else if (mt >= 0 && cur == m && $urandom_range(0, 3) == 0) begin
          req[m] = 1'b0;  // dropping req after grant must not cancel
        end
      end
      @(negedge clk);
      if (mt < 0) begin
        p = pick(r_edge, mlast);
        chk("rnd_capture_gnt", gnt, (p < 0) ? '0 : oh(p));
        if (p >= 0) begin
          cur = p; cur_we = w_edge[p]; cur_a = a_edge[p]; cur_w = d_edge[p]; mt = 0;
        end
      end else begin
        mt++;
      end
      if (mt > LAT) begin
        chk("rnd_gap_gnt", gnt, 0);
        chk("rnd_gap_ack", ack, 0);
        chk("rnd_gap_write", mem_write, 0);
        mt = -1;
      end else if (mt >= 0) begin
        chk("rnd_gnt", gnt, oh(cur));
        chk("rnd_mem_addr", mem_addr, cur_a);
        chk("rnd_mem_write", mem_write, (mt < LAT) ? cur_we : 1'b0);
        if (cur_we) chk("rnd_mem_wdata", mem_wdata, cur_w);
        if (mt == LAT) begin
          if (!cur_we) m_rdata = cur_a ^ K;
          chk("rnd_ack", ack, oh(cur));
          chk("rnd_rdata", rdata, m_rdata);
          chk("rnd_err", err, (cur_a[1:0] == 2'b11) ? oh(cur) : '0);
          mlast = cur; pend[cur] = 1'b0;
        end else begin
          chk("rnd_ack_early", ack, 0);
          chk("rnd_err_early", err, 0);
        end
      end else begin
        chk("rnd_idle_ack", ack, 0);
        chk("rnd_idle_write", mem_write, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
